// File: rtl/serial_adder_operand_serializer.sv
// Parallel-to-serial front end for a bit-serial adder: takes an operand pair,
// emits both LSB first and tells the adder when to clear its carry.
module serial_adder_operand_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_a,
    input  logic [WIDTH-1:0] up_b,
    output logic             a,
    output logic             b,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic             adder_clr
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT} state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic [WIDTH-1:0] sh_a, sh_b, sh_a_next, sh_b_next;
    logic             at_last;
    logic             handshake;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            sh_a  <= '0;
            sh_b  <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            sh_a  <= sh_a_next;
            sh_b  <= sh_b_next;
        end
    end

    // Outputs decode from state/idx/shift registers only; up_valid affects next state alone.
    always_comb begin
        at_last    = (state == SHIFT) && (idx == LAST_IDX);
        up_ready   = (state == IDLE) || at_last;
        handshake  = up_valid && up_ready;
        ser_valid  = (state == SHIFT);
        adder_clr  = !ser_valid;
        a          = ser_valid && sh_a[0];
        b          = ser_valid && sh_b[0];
        ser_first  = ser_valid && (idx == '0);
        ser_last   = at_last;

        state_next = state;
        idx_next   = idx;
        sh_a_next  = sh_a;
        sh_b_next  = sh_b;

        case (state)
            IDLE: begin
                if (handshake) begin
                    sh_a_next  = up_a;
                    sh_b_next  = up_b;
                    idx_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                sh_a_next = sh_a >> 1;
                sh_b_next = sh_b >> 1;
                idx_next  = idx + IDX_W'(1);
                if (at_last) begin
                    idx_next = '0;
                    // A pair accepted on the last bit waits one CLEAR cycle so carry cannot leak.
                    if (handshake) begin
                        sh_a_next  = up_a;
                        sh_b_next  = up_b;
                        state_next = CLEAR;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            CLEAR: begin
                idx_next   = '0;
                state_next = SHIFT;
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_adder_operand_serializer.sv
// Scoreboard bench: driver predicts accepted words from a cycle-count model,
// monitor pops expected serial bits whenever the DUT shows ser_valid.
module tb_serial_adder_operand_serializer;

    localparam int W = 4;

    typedef struct packed {
        logic a;
        logic b;
        logic first;
        logic last;
    } bit_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         up_valid = 1'b0;
    logic [W-1:0] up_a = '0;
    logic [W-1:0] up_b = '0;
    logic         up_ready, a, b, ser_valid, ser_first, ser_last, adder_clr;

    logic         up_valid1 = 1'b0;
    logic [0:0]   up_a1 = '0;
    logic [0:0]   up_b1 = '0;
    logic         up_ready1, a1, b1, ser_valid1, ser_first1, ser_last1, adder_clr1;

    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    bit_t sb[$];

    // Model: bits still owed for the current word, plus a pending clear cycle.
    int   m_left = 0;
    bit   m_clear = 1'b0;

    always #5 clk = ~clk;

    serial_adder_operand_serializer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(up_ready),
        .up_a(up_a), .up_b(up_b), .a(a), .b(b), .ser_valid(ser_valid),
        .ser_first(ser_first), .ser_last(ser_last), .adder_clr(adder_clr)
    );

    serial_adder_operand_serializer #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .up_valid(up_valid1), .up_ready(up_ready1),
        .up_a(up_a1), .up_b(up_b1), .a(a1), .b(b1), .ser_valid(ser_valid1),
        .ser_first(ser_first1), .ser_last(ser_last1), .adder_clr(adder_clr1)
    );

    function automatic bit model_ready();
        return !m_clear && (m_left <= 1);
    endfunction

    function automatic bit model_valid();
        return !m_clear && (m_left > 0);
    endfunction

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Drives one cycle of inputs, then advances the model across the clock edge.
    task automatic apply_stimulus(input bit r, input bit v, input logic [W-1:0] ia, input logic [W-1:0] ib);
        bit hs;
        rst      = r;
        up_valid = v;
        up_a     = ia;
        up_b     = ib;
        @(posedge clk);
        if (r) begin
            m_left  = 0;
            m_clear = 1'b0;
            sb.delete();
        end else begin
            hs = v && model_ready();
            if (m_clear) begin
                m_clear = 1'b0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0 && hs) begin
                    m_left  = W;
                    m_clear = 1'b1;
                end
            end else if (hs) begin
                m_left = W;
            end
            if (hs) begin
                for (int i = 0; i < W; i++)
                    sb.push_back('{a: ia[i], b: ib[i], first: (i == 0), last: (i == W - 1)});
            end
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            bit_t e;
            check_output("up_ready", up_ready, model_ready());
            check_output("ser_valid", ser_valid, model_valid());
            check_output("adder_clr", adder_clr, !model_valid());
            if (ser_valid) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("[TB] FAIL sb_underflow: got bit with empty scoreboard at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    check_output("bit_a", a, e.a);
                    check_output("bit_b", b, e.b);
                    check_output("ser_first", ser_first, e.first);
                    check_output("ser_last", ser_last, e.last);
                end
            end else begin
                check_output("idle_ab_flags", {a, b, ser_first, ser_last}, 4'b0000);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic d1a[0:7];
        logic d1b[0:7];

        apply_stimulus(1, 0, '0, '0);
        apply_stimulus(1, 1, 4'hA, 4'h5);
        mon_en = 1'b1;

        // Single word then idle.
        apply_stimulus(0, 1, 4'b1011, 4'b0110);
        repeat (5) apply_stimulus(0, 0, '0, '0);

        // Stall with valid held high, second pair taken on the last bit.
        apply_stimulus(0, 1, 4'b1011, 4'b0110);
        apply_stimulus(0, 1, 4'h3, 4'hC);
        apply_stimulus(0, 1, 4'h3, 4'hC);
        apply_stimulus(0, 1, 4'h3, 4'hC);
        apply_stimulus(0, 1, 4'hF, 4'h1);
        repeat (6) apply_stimulus(0, 0, '0, '0);

        // Reset in the middle of a word, then a clean restart.
        apply_stimulus(0, 1, 4'h9, 4'h6);
        apply_stimulus(0, 0, '0, '0);
        apply_stimulus(1, 1, 4'h7, 4'h7);
        apply_stimulus(0, 1, 4'h5, 4'hA);
        repeat (5) apply_stimulus(0, 0, '0, '0);

        for (int n = 0; n < 400; n++)
            apply_stimulus($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 60,
                           W'($urandom), W'($urandom));
        repeat (6) apply_stimulus(0, 0, '0, '0);
        check_output("sb_drained", sb.size(), 0);

        // WIDTH=1 instance: valid held high alternates bit and CLEAR cycles.
        for (int e = 0; e < 8; e++) begin
            d1a[e] = 1'($urandom);
            d1b[e] = 1'($urandom);
        end
        d1a[0] = 1'b1;
        d1b[0] = 1'b1;
        up_valid1 = 1'b1;
        for (int k = 0; k < 7; k++) begin
            up_a1 = d1a[k];
            up_b1 = d1b[k];
            apply_stimulus(0, 0, '0, '0);
            @(negedge clk);
            if (k % 2 == 0) begin
                int src;
                src = (k == 0) ? 0 : k - 1;
                check_output("w1_bit_ready_valid_clr", {up_ready1, ser_valid1, adder_clr1}, 3'b110);
                check_output("w1_ab", {a1, b1}, {d1a[src], d1b[src]});
                check_output("w1_first_last", {ser_first1, ser_last1}, 2'b11);
            end else begin
                check_output("w1_clear", {up_ready1, ser_valid1, adder_clr1, a1, b1, ser_first1, ser_last1},
                             7'b0010000);
            end
            #1;
        end
        up_valid1 = 1'b0;
        apply_stimulus(0, 0, '0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_adder_operand_serializer.md
SERIAL_ADDER_OPERAND_SERIALIZER -- requirements
Module: serial_adder_operand_serializer

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 1..32.
REQ-002 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: up_valid  input  1  parallel operand pair offered.
REQ-005 Port: up_ready  output  1  serializer accepts the pair this cycle.
REQ-006 Port: up_a  input  WIDTH  operand A, sampled only on handshake.
REQ-007 Port: up_b  input  WIDTH  operand B, sampled only on handshake.
REQ-008 Port: a  output  1  serial bit of A, LSB first; feeds adder input a.
REQ-009 Port: b  output  1  serial bit of B, LSB first; feeds adder input b.
REQ-010 Port: ser_valid  output  1  a/b carry a live operand bit.
REQ-011 Port: ser_first  output  1  current bit is bit 0 of a word.
REQ-012 Port: ser_last  output  1  current bit is bit WIDTH-1 of a word.
REQ-013 Port: adder_clr  output  1  carry-clear request; drives the downstream adder's synchronous reset, OR-ed with rst by the integrator.

Function
REQ-014 Handshake: transfer occurs on a cycle with up_valid & up_ready; no transfer means up_a/up_b are ignored.
REQ-015 States: IDLE, CLEAR, SHIFT; a bit index idx counts 0..WIDTH-1 in SHIFT.
REQ-016 IDLE: up_ready=1, adder_clr=1, ser_valid=0, a=b=0; on handshake, load shift registers with up_a/up_b, set idx=0, next state SHIFT; otherwise stay IDLE.
REQ-017 Latency: bit 0 appears on a/b in the cycle after the handshake, because the adder carry is already cleared by adder_clr in IDLE.
REQ-018 SHIFT: ser_valid=1, adder_clr=0, a/b = LSBs of the shift registers, ser_first=(idx==0), ser_last=(idx==WIDTH-1); each cycle shift both registers right by one and increment idx.
REQ-019 SHIFT with idx<WIDTH-1: up_ready=0.
REQ-020 SHIFT with idx==WIDTH-1: up_ready=1; on handshake, load the new pair and go to CLEAR; otherwise go to IDLE.
REQ-021 CLEAR: one cycle only, ser_valid=0, adder_clr=1, up_ready=0, a=b=0, ser_first=ser_last=0; next state SHIFT with idx=0.
REQ-022 Throughput: back-to-back words occupy WIDTH+1 cycles each (WIDTH bits plus one CLEAR); a single word occupies WIDTH cycles after the handshake.
REQ-023 ser_first and ser_last are 0 whenever ser_valid=0; with WIDTH=1 both are 1 on the single bit cycle.
REQ-024 Operand bits are emitted exactly once, in order bit0..bitWIDTH-1; no bit is dropped or repeated, regardless of up_valid activity during SHIFT.
REQ-025 All outputs except up_ready are driven from registers or decoded state only, with no combinational path from up_valid/up_a/up_b; up_ready depends on state and idx only.

Reset
REQ-026 On a cycle with rst=1, the next state is IDLE, idx=0, shift registers=0, and any word in flight is discarded.
REQ-027 In the cycle after rst: up_ready=1, adder_clr=1, ser_valid=0, ser_first=0, ser_last=0, a=0, b=0.
REQ-028 While rst=1, any handshake is ignored and no operand is loaded.

Verification (WIDTH=4 unless noted)
REQ-029 Reset: rst high 2 cycles, then low -> up_ready=1, adder_clr=1, ser_valid=0, a=b=0.
REQ-030 Single word: handshake at cycle 0 with up_a=4'b1011, up_b=4'b0110 -> cycles 1..4 give a=1,1,0,1 and b=0,1,1,0; ser_first only at cycle 1, ser_last only at cycle 4; up_ready=0 at cycles 1-3 and 1 at cycle 4; with up_valid=0, IDLE from cycle 5; the downstream adder's sum bits 1,0,0,0 (4'b0001, carry out 1).
REQ-031 Back-to-back: second pair 4'hF/4'h1 offered and accepted at cycle 4 -> cycle 5 is CLEAR (ser_valid=0, adder_clr=1); cycles 6..9 give a=1,1,1,1 and b=1,0,0,0; adder sum 0,0,0,0 with no carry leaking from word 1.
REQ-032 Stall: up_valid held high from cycle 1 -> no handshake until cycle 4; bits of the first word are unchanged.
REQ-033 Reset mid-word: rst=1 at cycle 2 of a word -> cycle 3 is IDLE with ser_valid=0 and up_ready=1; a new handshake at cycle 3 starts a clean word at cycle 4 with ser_first=1.
REQ-034 WIDTH=1: handshake with up_a=1, up_b=1 -> the next cycle has a=b=1 and ser_first=ser_last=1 with up_ready=1; back-to-back words alternate bit and CLEAR cycles.
